// File: rtl/dragon_pkg.sv
// Shared types and helpers for the dragon body queue.
package dragon_pkg;

    typedef enum logic [1:0] {
        LU_MOVE = 2'b00,
        LU_HEAL = 2'b01,
        LU_HIT  = 2'b10,
        LU_IDLE = 2'b11
    } lu_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    function automatic int seg_w(input int orient_w, input int pos_w);
        return orient_w + pos_w;
    endfunction

endpackage

// File: rtl/move_timer.sv
// Frame-tick divider: emits a one-cycle step every MOVE_PERIOD frame ticks.
module move_timer #(
    parameter int MOVE_PERIOD = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic enable,
    output logic step
);

    localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MOVE_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    assign step = enable & frame_tick & (cnt == LAST);

    // Count frame ticks while enabled; hold the count otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (enable && frame_tick) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dragon_body_queue.sv
// Dragon body segment queue: head-history shift register, thermometer
// visible-length mask, self-collision detect and a terminal DEAD state.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_RUN  | normal play: queue steps, length follows HEAL/HIT
//   ST_DEAD | last segment lost: everything frozen until reset
module dragon_body_queue
    import dragon_pkg::*;
#(
    parameter int MAX_SEGMENTS = 7,
    parameter int POS_W        = 8,
    parameter int ORIENT_W     = 2,
    parameter int MOVE_PERIOD  = 10,
    localparam int SEG_W       = seg_w(ORIENT_W, POS_W),
    localparam int LEN_W       = $clog2(MAX_SEGMENTS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic [1:0]                    length_update,
    input  logic [SEG_W-1:0]              head_in,
    output logic [MAX_SEGMENTS*SEG_W-1:0] segments,
    output logic [MAX_SEGMENTS-1:0]       display_en,
    output logic [LEN_W-1:0]              length,
    output logic                          move_strobe,
    output logic                          self_hit,
    output logic                          dead
);

    state_t state, state_next;

    logic                    step;
    logic                    hit_any;
    logic [MAX_SEGMENTS-1:0] en_next;
    logic [LEN_W-1:0]        len_next;
    logic [SEG_W-1:0]        seg_q [MAX_SEGMENTS];

    move_timer #(
        .MOVE_PERIOD (MOVE_PERIOD)
    ) u_move_timer (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .enable     (state == ST_RUN),
        .step       (step)
    );

    assign dead = (state == ST_DEAD);

    genvar g;
    generate
        for (g = 0; g < MAX_SEGMENTS; g++) begin : g_flat
            assign segments[g*SEG_W +: SEG_W] = seg_q[g];
        end
    endgenerate

    // Compare the head position against every visible pre-shift slot.
    always_comb begin
        hit_any = 1'b0;
        for (int k = 0; k < MAX_SEGMENTS; k++) begin
            if (display_en[k] && (seg_q[k][POS_W-1:0] == head_in[POS_W-1:0])) begin
                hit_any = 1'b1;
            end
        end
    end

    // Next state and next length/mask from the length command.
    always_comb begin
        state_next = state;
        en_next    = display_en;
        len_next   = length;
        if (state == ST_RUN) begin
            case (length_update)
                LU_HEAL: begin
                    if (length < LEN_W'(MAX_SEGMENTS)) begin
                        en_next  = (display_en << 1) | MAX_SEGMENTS'(1);
                        len_next = length + 1'b1;
                    end
                end
                LU_HIT: begin
                    if (length > LEN_W'(1)) begin
                        en_next  = display_en >> 1;
                        len_next = length - 1'b1;
                    end else if (length == LEN_W'(1)) begin
                        en_next    = '0;
                        len_next   = '0;
                        state_next = ST_DEAD;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Length mask, count and step-aligned pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            display_en  <= '0;
            length      <= '0;
            move_strobe <= 1'b0;
            self_hit    <= 1'b0;
        end else begin
            display_en  <= en_next;
            length      <= len_next;
            move_strobe <= step;
            self_hit    <= step & hit_any;
        end
    end

    // Head-history shift; the oldest entry falls off the end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < MAX_SEGMENTS; k++) begin
                seg_q[k] <= '0;
            end
        end else if (step) begin
            seg_q[0] <= head_in;
            for (int k = 1; k < MAX_SEGMENTS; k++) begin
                seg_q[k] <= seg_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_dragon_body_queue.sv
// Directed table-driven bench for dragon_body_queue at default parameters.
module tb_dragon_body_queue;
    import dragon_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [1:0]  length_update;
    logic [9:0]  head_in;
    logic [69:0] segments;
    logic [6:0]  display_en;
    logic [2:0]  length;
    logic        move_strobe;
    logic        self_hit;
    logic        dead;

    dragon_body_queue dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .length_update (length_update),
        .head_in       (head_in),
        .segments      (segments),
        .display_en    (display_en),
        .length        (length),
        .move_strobe   (move_strobe),
        .self_hit      (self_hit),
        .dead          (dead)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ft;
        logic [1:0]  lu;
        logic [9:0]  head;
        int          reps;
        logic [6:0]  en;
        logic [2:0]  len;
        logic        strb;
        logic        sh;
        logic        dd;
        logic [69:0] segs;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [69:0] s7(input logic [9:0] s0, s1, s2, s3, s4, s5, s6);
        return {s6, s5, s4, s3, s2, s1, s0};
    endfunction

    function automatic vec_t mk(input logic rst, ft, input logic [1:0] lu,
                                input logic [9:0] head, input int reps,
                                input logic [6:0] en, input logic [2:0] len,
                                input logic strb, sh, dd, input logic [69:0] segs);
        vec_t v;
        v.rst = rst; v.ft = ft; v.lu = lu; v.head = head; v.reps = reps;
        v.en = en; v.len = len; v.strb = strb; v.sh = sh; v.dd = dd; v.segs = segs;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [69:0] got, input logic [69:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL v%0d %s: got %h want %h", idx, name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        reset = 1'b0; frame_tick = 1'b0; length_update = LU_IDLE; head_in = '0;

        // rst ft lu head reps | en len strb sh dead segs
        tbl.push_back(mk(0, 0, LU_IDLE, 10'h000,  2, 7'h00, 3'd0, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h1A5,  9, 7'h00, 3'd0, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h1A5,  1, 7'h00, 3'd0, 1, 0, 0, s7(10'h1A5, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, LU_IDLE, 10'h1A5,  1, 7'h00, 3'd0, 0, 0, 0, s7(10'h1A5, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, LU_HEAL, 10'h000,  3, 7'h07, 3'd3, 0, 0, 0, s7(10'h1A5, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, LU_HEAL, 10'h000,  9, 7'h7F, 3'd7, 0, 0, 0, s7(10'h1A5, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, LU_HIT,  10'h000,  4, 7'h07, 3'd3, 0, 0, 0, s7(10'h1A5, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h011, 10, 7'h07, 3'd3, 1, 0, 0, s7(10'h011, 10'h1A5, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h022, 10, 7'h07, 3'd3, 1, 0, 0, s7(10'h022, 10'h011, 10'h1A5, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h033, 10, 7'h07, 3'd3, 1, 0, 0, s7(10'h033, 10'h022, 10'h011, 10'h1A5, 0, 0, 0)));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h122, 10, 7'h07, 3'd3, 1, 1, 0, s7(10'h122, 10'h033, 10'h022, 10'h011, 10'h1A5, 0, 0)));
        tbl.push_back(mk(1, 0, LU_IDLE, 10'h000,  1, 7'h07, 3'd3, 0, 0, 0, s7(10'h122, 10'h033, 10'h022, 10'h011, 10'h1A5, 0, 0)));
        tbl.push_back(mk(1, 0, LU_HIT,  10'h000,  2, 7'h01, 3'd1, 0, 0, 0, s7(10'h122, 10'h033, 10'h022, 10'h011, 10'h1A5, 0, 0)));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h033, 10, 7'h01, 3'd1, 1, 0, 0, s7(10'h033, 10'h122, 10'h033, 10'h022, 10'h011, 10'h1A5, 0)));
        tbl.push_back(mk(1, 0, LU_HIT,  10'h000,  1, 7'h00, 3'd0, 0, 0, 1, s7(10'h033, 10'h122, 10'h033, 10'h022, 10'h011, 10'h1A5, 0)));
        tbl.push_back(mk(1, 1, LU_HEAL, 10'h055, 12, 7'h00, 3'd0, 0, 0, 1, s7(10'h033, 10'h122, 10'h033, 10'h022, 10'h011, 10'h1A5, 0)));
        tbl.push_back(mk(0, 1, LU_HEAL, 10'h055,  1, 7'h00, 3'd0, 0, 0, 0, '0));
        tbl.push_back(mk(1, 0, LU_HEAL, 10'h000,  2, 7'h03, 3'd2, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h044, 10, 7'h03, 3'd2, 1, 0, 0, s7(10'h044, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h055, 10, 7'h03, 3'd2, 1, 0, 0, s7(10'h055, 10'h044, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h066,  9, 7'h03, 3'd2, 0, 0, 0, s7(10'h055, 10'h044, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, LU_HEAL, 10'h066,  1, 7'h07, 3'd3, 1, 0, 0, s7(10'h066, 10'h055, 10'h044, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, LU_IDLE, 10'h000,  1, 7'h00, 3'd0, 0, 0, 0, '0));
        tbl.push_back(mk(1, 0, LU_HIT,  10'h000,  2, 7'h00, 3'd0, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, LU_IDLE, 10'h077, 10, 7'h00, 3'd0, 1, 0, 0, s7(10'h077, 0, 0, 0, 0, 0, 0)));

        foreach (tbl[i]) begin
            reset         = tbl[i].rst;
            frame_tick    = tbl[i].ft;
            length_update = tbl[i].lu;
            head_in       = tbl[i].head;
            repeat (tbl[i].reps) @(posedge clk);
            #1;
            n_vec++;
            chk(i, "display_en",  70'(display_en),  70'(tbl[i].en));
            chk(i, "length",      70'(length),      70'(tbl[i].len));
            chk(i, "move_strobe", 70'(move_strobe), 70'(tbl[i].strb));
            chk(i, "self_hit",    70'(self_hit),    70'(tbl[i].sh));
            chk(i, "dead",        70'(dead),        70'(tbl[i].dd));
            chk(i, "segments",    segments,         tbl[i].segs);
        end

        // Step latency from a freshly wrapped counter: strobe on the 10th tick.
        frame_tick = 1'b1; length_update = LU_IDLE; head_in = 10'h088;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (move_strobe) seen = 1'b1;
        end
        frame_tick = 1'b0;
        n_vec++;
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL step_latency: no move_strobe within %0d ticks, want 10", n);
        end else begin
            chk(100, "step_latency", 70'(n), 70'd10);
            chk(100, "slot0_after_step", 70'(segments[9:0]), 70'h088);
        end
        @(posedge clk);
        #1;
        chk(101, "strobe_one_cycle", 70'(move_strobe), 70'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
